seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multicycle ALU for the multi-cycle CPU datapath. It extends the 2-bit-control add/sub/and/nor unit to WIDTH-bit operands, a 3-bit op code, signed compare, and iterative unsigned multiply and divide with a start/done handshake. The block registers its results, so the control FSM issues `start` and waits for `done` before latching `res`/`res_hi` into its ALUOut and HI/LO registers.

## Interface
- `WIDTH`, default 32: operand and result width, ≥ 4.
- `CNT_W`, default $clog2(WIDTH+1): iteration counter width.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: request; sampled only when `busy`=0.
- `op`  in  3: 000 add, 001 sub, 010 and, 011 nor, 100 or, 101 slt (signed), 110 mulu, 111 divu.
- `in_A`, `in_B`  in  WIDTH: operands, sampled on the accepting edge only.
- `res`  out  WIDTH: result; low product for mulu, quotient for divu.
- `res_hi`  out  WIDTH: high product for mulu, remainder for divu, 0 for all other ops.
- `zero`  out  1: registered (`res`==0).
- `ovf`  out  1: signed overflow for add/sub, 0 for all other ops.
- `dbz`  out  1: divide by zero, divu only.
- `busy`  out  1: high while in CALC.
- `done`  out  1: one-cycle pulse marking new result outputs.

## Operation
- FSM states:
  - IDLE: `start`=1 with op 000–101 computes the result into the output registers and goes to DONE. `start`=1 with op 110/111 loads operands, op and counter=0, then goes to CALC.
  - CALC: one iteration per edge. On the edge where counter reaches WIDTH-1, write the outputs and go to DONE.
  - DONE: `done`=1 this cycle. `start` is accepted here exactly as in IDLE (back-to-back issue). Otherwise go to IDLE.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH. `ovf` = operands' signs agree (for sub: A and ~B) and the result sign differs.
  - slt: `res` = {0…,1} when signed A < signed B.
- mulu: shift-add over an internal 2·WIDTH accumulator, with the multiplier's LSB tested each iteration. Output is {`res_hi`,`res`} = A·B.
- divu: restoring division over WIDTH iterations. `res` = A/B, `res_hi` = A%B.
  - B==0: `res` = all ones, `res_hi` = A, `dbz`=1, and the full WIDTH iterations still run (constant latency).
- Output hold: `res`, `res_hi`, `zero`, `ovf` and `dbz` change only on the edge that raises `done`, and hold until the next result.
- Ignored input: `start` while `busy`=1 is dropped and not queued. `in_A`, `in_B` and `op` may change freely after acceptance.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, counter 0, and every output 0 (`res`, `res_hi`, `zero`, `ovf`, `dbz`, `busy`, `done`).
  - Reset mid-CALC aborts the operation with no `done` pulse.
  - Reset has priority over `start` on the same edge.
  - Note `zero`=0 after reset even though `res`=0.
- Latency, with the accepting edge as edge 0:
  - ops 000–101: `done` is high in the cycle after edge 0 (1 cycle).
  - mulu/divu: `busy` is high for cycles 1..WIDTH-1. The outputs update on edge WIDTH and `done` is high in the cycle after edge WIDTH (WIDTH cycles).
- Throughput:
  - Simple ops can issue every cycle: `start` held high with the DONE-state acceptance gives a new result every cycle.
  - mul/div issue at most once per WIDTH cycles.
- `busy` and `done` are never high together.

## Structure
- Shared package `alu_pkg`: op-code localparams (`OP_ADD`…`OP_DIVU`) and the state encoding (IDLE, CALC, DONE). The CPU control FSM imports the same op codes.
- Sub-module `seq_alu_iter`: holds the mul/div datapath (accumulator, shifted operand, counter, one iteration per enable). It exposes `load`, `en`, `is_div`, `last` and the two result words.
- The top level holds the FSM, the combinational simple-op path and the output registers.

## Test plan
All scenarios at WIDTH=32.
- Simple ops back-to-back: `start` held high, op add 0x7FFFFFFF+1, then sub 5-5, then nor 0|0. Required: three consecutive `done` cycles with `res`=0x80000000 (`ovf`=1), then `res`=0 (`zero`=1), then `res`=0xFFFFFFFF.
- slt: A=0xFFFFFFFF, B=1 → `res`=1. Unsigned-large A=0x80000000, B=0 → `res`=1.
- mulu: 0xFFFFFFFF×0xFFFFFFFF → `res_hi`=0xFFFFFFFE, `res`=0x00000001. `done` appears exactly 32 cycles after acceptance and `busy` stays high during cycles 1–31.
- divu: 100/7 → `res`=14, `res_hi`=2, `dbz`=0. Then 9/0 → `res`=0xFFFFFFFF, `res_hi`=9, `dbz`=1, with the same latency.
- `start` pulsed during CALC with op add → ignored: exactly one `done`, carrying the mul/div result.
- `rst_n` low at cycle 10 of a divu → no `done`, all outputs 0. The next add 2+3 completes with `res`=5 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU and the CPU control FSM:
// op codes, controller state encoding and op classification.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // mulu and divu are the only ops that go through the iterative datapath
  function automatic logic is_iter_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for unsigned multiply (shift-add) and unsigned
// restoring divide. One iteration per enabled edge. o_hi/o_lo present the
// result of the iteration being performed this cycle, so the caller can
// capture the final words on the same edge that performs the last step.
module seq_alu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             is_div,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  // {r_hi, r_lo} is the 2*WIDTH accumulator. For mul, r_lo starts as the
  // multiplier and is shifted out LSB-first; for div, r_lo starts as the
  // dividend and fills up with quotient bits.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dsh;
  logic [WIDTH-1:0] w_ddiff;
  logic             w_dge;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  // One multiply or divide step computed from the current accumulator
  always_comb begin
    w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_dsh   = {r_hi, r_lo[WIDTH-1]};
    w_dge   = (w_dsh >= {1'b0, r_b});
    // Only used when w_dge, where the true difference fits in WIDTH bits
    w_ddiff = w_dsh[WIDTH-1:0] - r_b;
    if (r_div) begin
      w_hi_n = w_dge ? w_ddiff : w_dsh[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_dge};
    end else begin
      w_hi_n = w_msum[WIDTH:1];
      w_lo_n = {w_msum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_hi = w_hi_n;
  assign o_lo = w_lo_n;
  assign last = (r_cnt == CNT_W'(WIDTH - 1));

  // Iteration counter; the only state here that needs a defined reset value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Accumulator and operand registers: load on accept, step when enabled
  always_ff @(posedge clk) begin
    if (load) begin
      r_div <= is_div;
      r_hi  <= '0;
      r_lo  <= is_div ? in_A : in_B;
      r_b   <= is_div ? in_B : in_A;
    end else if (en) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle add/sub/and/nor/or/slt and WIDTH-cycle
// unsigned mulu/divu, with registered outputs and a start/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_next;
  logic             w_accept;
  logic             w_iter;
  logic             w_last;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dbz;

  // Signed overflow: operand signs agree but result sign differs.
  // For subtraction the caller passes the inverted B sign.
  function automatic logic f_ovf(input logic a_s, input logic b_s,
                                 input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  assign w_accept = start && (r_state != ST_CALC);
  assign w_iter   = w_accept && is_iter_op(op);

  // Simple-op result path, evaluated on the accepting cycle
  always_comb begin
    w_sum = in_A + in_B;
    w_dif = in_A - in_B;
    w_res = '0;
    w_ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = f_ovf(in_A[WIDTH-1], in_B[WIDTH-1], w_sum[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = f_ovf(in_A[WIDTH-1], ~in_B[WIDTH-1], w_dif[WIDTH-1]);
      end
      OP_AND:  w_res = in_A & in_B;
      OP_NOR:  w_res = ~(in_A | in_B);
      OP_OR:   w_res = in_A | in_B;
      OP_SLT:  w_res[0] = ($signed(in_A) < $signed(in_B));
      default: w_res = '0;
    endcase
  end

  // Next-state logic; DONE accepts a new request exactly like IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_next = w_iter ? ST_CALC : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register; reset wins over a same-edge start and aborts CALC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember divide-by-zero at accept time; operands may change afterwards
  always_ff @(posedge clk) begin
    if (w_iter) begin
      r_dbz_pend <= op[0] && (in_B == '0);
    end
  end

  // Output registers change only on the edge that raises done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_res    <= w_res;
      r_res_hi <= '0;
      r_zero   <= (w_res == '0);
      r_ovf    <= w_ovf;
      r_dbz    <= 1'b0;
    end else if ((r_state == ST_CALC) && w_last) begin
      r_res    <= w_lo;
      r_res_hi <= w_hi;
      r_zero   <= (w_lo == '0);
      r_ovf    <= 1'b0;
      r_dbz    <= r_dbz_pend;
    end
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_iter),
    .en     (r_state == ST_CALC),
    .is_div (op[0]),
    .in_A   (in_A),
    .in_B   (in_B),
    .last   (w_last),
    .o_lo   (w_lo),
    .o_hi   (w_hi)
  );

  assign res    = r_res;
  assign res_hi = r_res_hi;
  assign zero   = r_zero;
  assign ovf    = r_ovf;
  assign dbz    = r_dbz;
  assign busy   = (r_state == ST_CALC);
  assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  in_A;
  logic [W-1:0]  in_B;
  logic [W-1:0]  res;
  logic [W-1:0]  res_hi;
  logic          zero;
  logic          ovf;
  logic          dbz;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .in_A   (in_A),
    .in_B   (in_B),
    .res    (res),
    .res_hi (res_hi),
    .zero   (zero),
    .ovf    (ovf),
    .dbz    (dbz),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         z;
    logic         v;
    logic         d;
  } exp_t;

  // Reference: plain arithmetic on wide integers
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint sa;
    longint sb;
    longint s;
    logic [63:0] p;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin
        s = sa + sb;
        e.r = a + b;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        s = sa - sb;
        e.r = a - b;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = ~(a | b);
      3'd4: e.r = a | b;
      3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: begin
        p = {32'd0, a} * {32'd0, b};
        e.r = p[31:0];
        e.h = p[63:32];
      end
      default: begin
        if (b == 0) begin
          e.r = '1;
          e.h = a;
          e.d = 1'b1;
        end else begin
          e.r = a / b;
          e.h = a % b;
        end
      end
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op as a single-cycle start pulse, wait for done, check all
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic        it;
    logic [W-1:0] prev;
    logic        busy_ok;
    logic        hold_ok;
    int          lat;
    e       = model(o, a, b);
    it      = o[2] & o[1];
    prev    = res;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat     = 0;
    @(negedge clk);
    start = 1'b1; op = o; in_A = a; in_B = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); in_A = $urandom; in_B = $urandom;
    while (!done && lat < 3 * W) begin
      if (lat >= 1 && !busy) busy_ok = 1'b0;
      if (res !== prev) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), it ? 64'(W) : 64'd0);
    if (it) begin
      chk({tag, ".busy"}, {63'd0, busy_ok}, 64'd1);
      chk({tag, ".hold"}, {63'd0, hold_ok}, 64'd1);
    end
    chk({tag, ".res"},    64'(res),    64'(e.r));
    chk({tag, ".res_hi"}, 64'(res_hi), 64'(e.h));
    chk({tag, ".flags"},  {61'd0, zero, ovf, dbz}, {61'd0, e.z, e.v, e.d});
    chk({tag, ".busy_done"}, {62'd0, busy, done}, 64'd1);
  endtask

  initial begin
    int n;
    logic [W-1:0] got;
    logic [2:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset with start held high: reset must win
    rst_n = 1'b0; start = 1'b1; op = 3'd0; in_A = 32'd1; in_B = 32'd2;
    repeat (3) @(negedge clk);
    chk("reset.res",    64'(res),    64'd0);
    chk("reset.res_hi", 64'(res_hi), 64'd0);
    chk("reset.ctrl", {59'd0, zero, ovf, dbz, busy, done}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back simple ops with start held high
    start = 1'b1; op = 3'd0; in_A = 32'h7FFFFFFF; in_B = 32'd1;
    @(negedge clk);
    chk("b2b.add", {30'd0, done, ovf, res}, {30'd0, 1'b1, 1'b1, 32'h80000000});
    op = 3'd1; in_A = 32'd5; in_B = 32'd5;
    @(negedge clk);
    chk("b2b.sub", {30'd0, done, zero, res}, {30'd0, 1'b1, 1'b1, 32'h0});
    op = 3'd3; in_A = 32'd0; in_B = 32'd0;
    @(negedge clk);
    chk("b2b.nor", {30'd0, done, zero, res}, {30'd0, 1'b1, 1'b0, 32'hFFFFFFFF});
    start = 1'b0;
    @(negedge clk);
    chk("b2b.idle", {63'd0, done}, 64'd0);

    // slt, signed interpretation
    run_op("slt_neg", 3'd5, 32'hFFFFFFFF, 32'd1);
    chk("slt_neg.const", 64'(res), 64'd1);
    run_op("slt_big", 3'd5, 32'h80000000, 32'd0);
    chk("slt_big.const", 64'(res), 64'd1);

    // mulu and divu
    run_op("mulu_max", 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulu_max.const", {res_hi, res}, 64'hFFFFFFFE_00000001);
    run_op("divu", 3'd7, 32'd100, 32'd7);
    chk("divu.const", {res_hi, res}, {32'd2, 32'd14});
    run_op("divu0", 3'd7, 32'd9, 32'd0);
    chk("divu0.const", {31'd0, dbz, res_hi, res}, {31'd0, 1'b1, 32'd9, 32'hFFFFFFFF});

    // start pulsed during CALC is dropped
    @(negedge clk);
    start = 1'b1; op = 3'd6; in_A = 32'd3; in_B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; in_A = 32'd1; in_B = 32'd1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    got = '0;
    repeat (45) begin
      if (done) begin
        n++;
        got = res;
      end
      @(negedge clk);
    end
    chk("calc_start.count", 64'(n), 64'd1);
    chk("calc_start.res", 64'(got), 64'd15);

    // Reset in the middle of a divide
    start = 1'b1; op = 3'd7; in_A = 32'd100; in_B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.res", {res_hi, res}, 64'd0);
    chk("midrst.ctrl", {59'd0, zero, ovf, dbz, busy, done}, 64'd0);
    n = 0;
    repeat (40) begin
      if (done) n++;
      @(negedge clk);
    end
    chk("midrst.no_done", 64'(n), 64'd0);
    run_op("after_rst_add", 3'd0, 32'd2, 32'd3);
    chk("after_rst_add.const", 64'(res), 64'd5);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'd0;
      else if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 300));
      if ($urandom_range(0, 4) == 0) ra = {1'b0, 31'h7FFFFFFF} - 32'($urandom_range(0, 3));
      run_op("rand", ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // busy and done must never be high together
  always @(negedge clk) begin
    if (busy && done) begin
      tests++;
      fails++;
      $error("FAIL busy_and_done: observed busy=%b done=%b expected not both", busy, done);
    end
  end

endmodule
